// File: rtl/diag_pkg.sv
// Shared types and constants for the diagnostic loop sequencer.
package diag_pkg;

    localparam int DEFAULT_SYSTOLIC_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SWEEP = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } diag_state_e;

endpackage

// File: rtl/diag_loop_sequencer.sv
// Loads per-row fault vectors into the diagnostic loop chains, sweeps them once
// to log each row's single-PE faults to the eNVM, then latches the fault maps.
module diag_loop_sequencer
    import diag_pkg::*;
#(
    parameter int SYSTOLIC_SIZE = DEFAULT_SYSTOLIC_SIZE,
    parameter int ADDR_WIDTH    = $clog2(SYSTOLIC_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [SYSTOLIC_SIZE-1:0] row_fault,
    output logic                     chain_en,
    output logic [SYSTOLIC_SIZE-1:0] chain_col_inputs,
    input  logic [SYSTOLIC_SIZE-1:0] chain_single_pe,
    input  logic [SYSTOLIC_SIZE-1:0] chain_col_fault,
    input  logic [SYSTOLIC_SIZE-1:0] chain_row_fault,
    input  logic [ADDR_WIDTH-1:0]    chain_counter,
    output logic                     envm_we,
    output logic [ADDR_WIDTH-1:0]    envm_addr,
    output logic [SYSTOLIC_SIZE-1:0] envm_wdata,
    output logic [SYSTOLIC_SIZE-1:0] col_fault_map,
    output logic [SYSTOLIC_SIZE-1:0] row_fault_map,
    output logic                     busy,
    output logic                     done,
    output logic                     sync_err,
    output diag_state_e              state_dbg
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

    // Row handshake: a row transfers on any cycle where row_valid && row_ready;
    // row_ready is high for the whole LOAD state and the producer may stall freely.

    diag_state_e           state;
    logic [ADDR_WIDTH-1:0] idx;

    assign state_dbg = state;
    assign busy      = (state != IDLE);

    always_comb begin
        row_ready        = 1'b0;
        chain_en         = 1'b0;
        chain_col_inputs = '0;
        case (state)
            LOAD: begin
                row_ready = 1'b1;
                chain_en  = row_valid;
                if (row_valid) begin
                    chain_col_inputs = row_fault;
                end
            end
            SWEEP: begin
                chain_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            envm_we       <= 1'b0;
            envm_addr     <= '0;
            envm_wdata    <= '0;
            col_fault_map <= '0;
            row_fault_map <= '0;
            sync_err      <= 1'b0;
            done          <= 1'b0;
        end else begin
            envm_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD;
                        idx   <= '0;
                    end
                end
                LOAD: begin
                    if (row_valid) begin
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= SWEEP;
                        end else begin
                            idx <= idx + ADDR_WIDTH'(1);
                        end
                    end
                end
                SWEEP: begin
                    // idx is the sweep cycle number, so it doubles as row address
                    envm_we    <= 1'b1;
                    envm_addr  <= idx;
                    envm_wdata <= chain_single_pe;
                    if (chain_counter != idx) begin
                        sync_err <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= FLUSH;
                    end else begin
                        idx <= idx + ADDR_WIDTH'(1);
                    end
                end
                FLUSH: begin
                    col_fault_map <= chain_col_fault;
                    row_fault_map <= chain_row_fault;
                    state         <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_diag_loop_sequencer.sv
// Bench for diag_loop_sequencer with a behavioural diagnostic-chain model,
// table-driven runs, randomized runs and hand-written reset/sync sequences.
module tb_diag_loop_sequencer;
    import diag_pkg::*;

    localparam int N  = 8;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          row_valid;
    logic          row_ready;
    logic [N-1:0]  row_fault;
    logic          chain_en;
    logic [N-1:0]  chain_col_inputs;
    logic [N-1:0]  chain_single_pe;
    logic [N-1:0]  chain_col_fault;
    logic [N-1:0]  chain_row_fault;
    logic [AW-1:0] chain_counter;
    logic          envm_we;
    logic [AW-1:0] envm_addr;
    logic [N-1:0]  envm_wdata;
    logic [N-1:0]  col_fault_map;
    logic [N-1:0]  row_fault_map;
    logic          busy;
    logic          done;
    logic          sync_err;
    diag_state_e   state_dbg;

    int checks = 0;
    int errors = 0;

    diag_loop_sequencer #(.SYSTOLIC_SIZE(N)) dut (
        .clk(clk), .rst(rst), .start(start),
        .row_valid(row_valid), .row_ready(row_ready), .row_fault(row_fault),
        .chain_en(chain_en), .chain_col_inputs(chain_col_inputs),
        .chain_single_pe(chain_single_pe), .chain_col_fault(chain_col_fault),
        .chain_row_fault(chain_row_fault), .chain_counter(chain_counter),
        .envm_we(envm_we), .envm_addr(envm_addr), .envm_wdata(envm_wdata),
        .col_fault_map(col_fault_map), .row_fault_map(row_fault_map),
        .busy(busy), .done(done), .sync_err(sync_err), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Chain environment: row memory indexed by a wrapping counter, OR-accumulating.
    logic [N*N-1:0] cmem;
    logic [AW-1:0]  ccnt;
    logic           chain_clr = 1'b0;
    logic           force_cnt1 = 1'b0;

    function automatic logic [N-1:0] col_rule(input logic [N*N-1:0] m);
        logic [N-1:0] r;
        r = '0;
        for (int c = 0; c < N; c++)
            for (int k = 0; k < N - 2; k++)
                if (m[k*N+c] && m[(k+1)*N+c] && m[(k+2)*N+c]) r[c] = 1'b1;
        return r;
    endfunction

    function automatic logic [N-1:0] row_rule(input logic [N*N-1:0] m);
        logic [N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++)
            for (int c = 0; c < N - 2; c++)
                if (m[k*N+c] && m[k*N+c+1] && m[k*N+c+2]) r[k] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        if (chain_clr) begin
            cmem <= '0;
            ccnt <= '0;
        end else if (chain_en) begin
            cmem[ccnt*N +: N] <= cmem[ccnt*N +: N] | chain_col_inputs;
            ccnt <= ccnt + 1'b1;
        end
    end

    always_comb begin
        chain_single_pe = cmem[ccnt*N +: N];
        chain_counter   = force_cnt1 ? AW'(1) : ccnt;
        chain_col_fault = col_rule(cmem);
        chain_row_fault = row_rule(cmem);
    end

    // driver / checker tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chain_reset();
        @(negedge clk);
        chain_clr = 1'b1;
        @(posedge clk);
        #1 chain_clr = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " row_ready"}, 32'(row_ready), 0);
        check({tag, " chain_en"}, 32'(chain_en), 0);
        check({tag, " chain_col_inputs"}, 32'(chain_col_inputs), 0);
        check({tag, " envm_we"}, 32'(envm_we), 0);
        check({tag, " envm_addr"}, 32'(envm_addr), 0);
        check({tag, " envm_wdata"}, 32'(envm_wdata), 0);
        check({tag, " col_map"}, 32'(col_fault_map), 0);
        check({tag, " row_map"}, 32'(row_fault_map), 0);
        check({tag, " sync_err"}, 32'(sync_err), 0);
        check({tag, " state"}, 32'(state_dbg), 32'(IDLE));
    endtask

    // mode 0: row_valid always high; 1: toggles starting low; 2: random
    task automatic run_vec(input string name, input logic [N*N-1:0] rows,
                           input logic [N*N-1:0] exp_rows, input logic [1:0] mode,
                           input bit glitch, input logic [N-1:0] ecol,
                           input logic [N-1:0] erow, input logic esync);
        logic [N-1:0] exp_q[$];
        int acc, cyc, load_len, done_cnt, done_at, first_wr, last_busy, exp_addr;
        bit fin, v, exp_en;
        for (int i = 0; i < N; i++) exp_q.push_back(exp_rows[i*N +: N]);
        acc = 0; cyc = 1; load_len = 0; done_cnt = 0; done_at = -1;
        first_wr = -1; last_busy = -1; exp_addr = 0; fin = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check({name, " busy after start"}, 32'(busy), 1);
        check({name, " row_ready after start"}, 32'(row_ready), 1);
        while (!fin && cyc < 200) begin
            @(negedge clk);
            start = (glitch && (cyc == 3 || cyc == N + 3)) ? 1'b1 : 1'b0;
            if (row_ready && acc < N) begin
                case (mode)
                    2'd0:    v = 1'b1;
                    2'd1:    v = (load_len % 2) == 1;
                    default: v = 1'($urandom_range(0, 1));
                endcase
                row_valid = v;
                row_fault = v ? rows[acc*N +: N] : N'($urandom);
                #1;
                check({name, " load chain_en"}, 32'(chain_en), 32'(v));
                check({name, " load col_inputs"}, 32'(chain_col_inputs),
                      v ? 32'(rows[acc*N +: N]) : 0);
                if (v) acc++;
                load_len++;
            end else begin
                row_valid = 1'($urandom_range(0, 1));
                row_fault = N'($urandom);
                #1;
                exp_en = (acc == N) && (cyc > load_len) && (cyc <= load_len + N);
                check({name, " chain_en"}, 32'(chain_en), 32'(exp_en));
                check({name, " idle col_inputs"}, 32'(chain_col_inputs), 0);
            end
            if (busy) last_busy = cyc;
            if (envm_we) begin
                if (first_wr < 0) first_wr = cyc;
                check({name, " envm_addr"}, 32'(envm_addr), 32'(exp_addr));
                exp_addr++;
                if (exp_q.size() == 0) check({name, " extra write"}, 1, 0);
                else check({name, " envm_wdata"}, 32'(envm_wdata), 32'(exp_q.pop_front()));
            end
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = cyc;
                    check({name, " busy at done"}, 32'(busy), 0);
                    check({name, " col_map"}, 32'(col_fault_map), 32'(ecol));
                    check({name, " row_map"}, 32'(row_fault_map), 32'(erow));
                    check({name, " sync_err"}, 32'(sync_err), 32'(esync));
                end
            end else if (done_at >= 0) begin
                check({name, " stays idle"}, 32'(busy), 0);
            end
            if (done_at >= 0 && cyc >= done_at + 2) fin = 1;
            @(posedge clk);
            cyc++;
        end
        row_valid = 1'b0;
        start = 1'b0;
        if (done_at < 0) begin
            check({name, " timeout waiting for done"}, 0, 1);
        end else begin
            check({name, " rows accepted"}, 32'(acc), N);
            if (mode == 2'd0) check({name, " load length"}, 32'(load_len), N);
            if (mode == 2'd1) check({name, " load length"}, 32'(load_len), 2 * N);
            check({name, " done cycle"}, 32'(done_at), 32'(load_len + N + 3));
            check({name, " done count"}, 32'(done_cnt), 1);
            check({name, " busy last cycle"}, 32'(last_busy), 32'(load_len + N + 2));
            check({name, " first write cycle"}, 32'(first_wr), 32'(load_len + 2));
            check({name, " write count"}, 32'(exp_addr), N);
        end
    endtask

    typedef struct packed {
        logic [N*N-1:0] rows;
        logic [1:0]     mode;
        bit             glitch;
        logic [N-1:0]   ecol;
        logic [N-1:0]   erow;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [N*N-1:0] ra, rb;
        start = 1'b0;
        row_valid = 1'b0;
        row_fault = '0;
        rst = 1'b1;

        // table of hand-derived vectors
        tbl[0] = '{rows: '0, mode: 2'd0, glitch: 1'b0, ecol: 8'h00, erow: 8'h00};
        tbl[1] = '{rows: '0, mode: 2'd0, glitch: 1'b0, ecol: 8'h00, erow: 8'h00};
        tbl[1].rows[2*N +: N] = 8'h10;
        tbl[2] = '{rows: {N{8'hE0}}, mode: 2'd0, glitch: 1'b0, ecol: 8'hE0, erow: 8'hFF};
        tbl[3] = '{rows: '0, mode: 2'd1, glitch: 1'b0, ecol: 8'h00, erow: 8'h00};
        for (int i = 0; i < N; i++) tbl[3].rows[i*N +: N] = 8'(1 << i);
        tbl[4] = '{rows: '0, mode: 2'd0, glitch: 1'b1, ecol: 8'h07, erow: 8'h07};
        for (int i = 0; i < 3; i++) tbl[4].rows[i*N +: N] = 8'h07;

        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            chain_reset();
            run_vec($sformatf("vec%0d", t), tbl[t].rows, tbl[t].rows, tbl[t].mode,
                    tbl[t].glitch, tbl[t].ecol, tbl[t].erow, 1'b0);
        end

        // randomized runs against rule-based expectations
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++)
                ra[i*N +: N] = N'($urandom) | (($urandom_range(0, 1) == 1) ? 8'h1C : 8'h00);
            chain_reset();
            run_vec($sformatf("rand%0d", t), ra, ra, 2'd2, 1'b0, col_rule(ra), row_rule(ra), 1'b0);
        end

        // second run without clearing the chain accumulates onto the first
        for (int i = 0; i < N; i++) begin
            ra[i*N +: N] = N'($urandom) & N'($urandom);
            rb[i*N +: N] = N'($urandom) & N'($urandom);
        end
        chain_reset();
        run_vec("sticky_a", ra, ra, 2'd0, 1'b0, col_rule(ra), row_rule(ra), 1'b0);
        run_vec("sticky_b", rb, ra | rb, 2'd2, 1'b0, col_rule(ra | rb), row_rule(ra | rb), 1'b0);

        // misaligned counter raises sync_err, which survives a clean run
        force_cnt1 = 1'b1;
        chain_reset();
        run_vec("sync_forced", {N{8'hE0}}, {N{8'hE0}}, 2'd0, 1'b0, 8'hE0, 8'hFF, 1'b1);
        force_cnt1 = 1'b0;
        chain_reset();
        run_vec("sync_sticky", {N{8'hE0}}, {N{8'hE0}}, 2'd0, 1'b0, 8'hE0, 8'hFF, 1'b1);

        // reset asserted in sweep cycle 3
        chain_reset();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        row_valid = 1'b1;
        row_fault = 8'h5A;
        repeat (N + 3) @(posedge clk);
        @(negedge clk);
        check("midrun envm_we before rst", 32'(envm_we), 1);
        row_valid = 1'b0;
        rst = 1'b1;
        #1 check_all_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_rst");

        chain_reset();
        ra = '0;
        ra[5*N +: N] = 8'h3C;
        run_vec("post_rst", ra, ra, 2'd0, 1'b0, 8'h00, 8'h20, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
